// File: rtl/instr_encoder.sv
// Instruction-memory loader: accepts decoded field sets, encodes them into
// 32-bit instruction words and writes them to consecutive word addresses.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [7:0]  limit,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  Cond,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic [3:0]  Rn,
  input  logic [3:0]  Rd,
  input  logic [11:0] Src2,
  input  logic [23:0] Imm24,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWD,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  word_count,
  output logic [7:0]  err_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] base_q;
  logic [7:0]  limit_q;
  logic        funct_ok;
  logic        legal;
  logic        accept;
  logic [31:0] enc_word;

  // Handshake: a field set transfers on a rising edge where in_valid and
  // in_ready are both 1; in_ready never depends on in_valid.
  assign in_ready  = (state == LOAD) && (word_count < limit_q);
  assign accept    = in_valid && in_ready;
  assign busy      = (state == LOAD);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_comb begin
    funct_ok = 1'b0;
    case (Funct[4:1])
      4'b0000, 4'b0010, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1010, 4'b1011,
      4'b1100, 4'b1101: funct_ok = 1'b1;
      default:          funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    legal    = (Op == 2'b01) || (Op == 2'b10) || ((Op == 2'b00) && funct_ok);
    enc_word = {Cond, Op, Funct, Rn, Rd, Src2};
    if (Op == 2'b10) enc_word = {Cond, 2'b10, Funct[5:4], Imm24};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      base_q     <= '0;
      limit_q    <= '0;
      MemWE      <= 1'b0;
      MemAddr    <= '0;
      MemWD      <= '0;
      err        <= 1'b0;
      word_count <= '0;
      err_count  <= '0;
    end else begin
      MemWE <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= LOAD;
            base_q     <= base_addr & ~32'h3;
            limit_q    <= limit;
            word_count <= '0;
            err_count  <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (legal) begin
              MemWE      <= 1'b1;
              MemAddr    <= base_q + {22'd0, word_count, 2'b00};
              MemWD      <= enc_word;
              word_count <= word_count + 8'd1;
            end else begin
              err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
          end
          // Reached only once the final write is already on the port.
          if (word_count == limit_q) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset; asserted while 0.
REQ-003 SHALL have port start, input, 1, begins a load session at base_addr.
REQ-004 SHALL have port base_addr, input, 32, byte address of first word; bits[1:0] ignored, treated as 0.
REQ-005 SHALL have port limit, input, 8, words to write per session; 0 means zero words.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the field-input handshake.
REQ-007 SHALL have field inputs Cond[3:0], Op[1:0], Funct[5:0], Rn[3:0], Rd[3:0], Src2[11:0], Imm24[23:0].
REQ-008 SHALL have outputs MemWE (1), MemAddr (32) and MemWD (32), the instruction-memory write port.
REQ-009 SHALL have outputs busy (1), done (1), err (1), word_count (8) and err_count (8).

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, DONE; reset state IDLE.
REQ-011 SHALL move IDLE->LOAD or DONE->LOAD on start=1, capturing base_addr and limit and clearing word_count and err_count.
REQ-012 SHALL ignore start while in LOAD.
REQ-013 SHALL drive in_ready=1 only in LOAD with word_count<limit; busy=1 exactly in LOAD; done=1 exactly in DONE.
REQ-014 SHALL accept a field set only on a cycle with in_valid=1 and in_ready=1.
REQ-015 SHALL encode Op=00 or Op=01 as {Cond,Op,Funct,Rn,Rd,Src2}, bits 31:0 MSB-first.
REQ-016 SHALL encode Op=10 as {Cond,2'b10,Funct[5:4],Imm24}, ignoring Rn, Rd, Src2 and Funct[3:0].
REQ-017 SHALL treat as illegal: Op=11, or Op=00 with Funct[4:1] outside {0000,0010,0100,0101,1000,1001,1010,1011,1100,1101}.
REQ-018 SHALL, for a legal accept, pulse MemWE=1 for one cycle on the next cycle, with MemWD=encoded word and MemAddr=captured base+4*word_count (mod 2^32), then increment word_count.
REQ-019 SHALL, for an illegal accept, produce no write and no word_count change, pulse err=1 for one cycle on the next cycle, and increment err_count saturating at 255.
REQ-020 SHALL sustain one accept per cycle, so back-to-back legal accepts yield consecutive MemWE pulses at consecutive addresses.
REQ-021 SHALL enter DONE on the cycle after the write that makes word_count equal limit; with limit=0, enter DONE the cycle after start with zero writes.
REQ-022 SHALL hold MemAddr and MemWD at their last values while MemWE=0.
REQ-023 SHALL keep word_count and err_count readable and stable in DONE until the next start.

Reset
REQ-024 SHALL, while reset=0, force state=IDLE, in_ready=0, MemWE=0, err=0, busy=0, done=0, MemAddr=0, MemWD=0, word_count=0 and err_count=0.
REQ-025 SHALL, on reset assertion mid-LOAD, suppress any pending MemWE pulse; that word is lost.
REQ-026 SHALL, after reset release, remain in IDLE until start.

Verification
REQ-027 SHALL pass: start with base=0x100, limit=2; ADD r1,r2,#5, i.e. Cond=E, Op=00, Funct=101000, Rn=2, Rd=1, Src2=005 -> MemWE at 0x100 with MemWD=0xE2821005.
REQ-028 SHALL pass: a branch with Cond=E, Op=10, Funct=10xxxx, Imm24=0xFFFFFE as the 2nd word -> write 0xEAFFFFFE at 0x104, then done=1 and in_ready=0.
REQ-029 SHALL pass: LDR with Op=01, Funct=011001 -> written unchanged; Op=11 -> err pulse, err_count=1, no write, address not advanced.
REQ-030 SHALL pass: 3 back-to-back legal accepts with limit=3 -> 3 consecutive MemWE cycles at base, base+4 and base+8.
REQ-031 SHALL pass: limit=0 -> DONE one cycle after start, no MemWE; start during LOAD -> ignored.
REQ-032 SHALL pass: reset=0 asynchronously in the cycle after an accept -> no MemWE pulse and all outputs zero.
